uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver for the uart0 serial link; the receive end of the design's UART, complementing the uart0_txd driver.
- Synchronises uart0_rxd into system_clk, samples each bit at mid-bit, and deframes 8N1 (optional parity) into bytes.
- Delivers bytes through a one-entry valid/ready holding register to the core logic, with framing-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 434, system_clk cycles per UART bit (50 MHz / 115200). Legal range 4..65535. HALF_BIT = CLKS_PER_BIT/2, truncated.

Ports:
- system_clk  input  1  sole clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- uart0_rxd  input  1  serial line, asynchronous to system_clk, idles high.
- rx_data  output  8  received byte, LSB = first data bit.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready on a rising edge.
- rx_busy  output  1  high in any state other than IDLE.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being consumed.
- rx_parity_err  output  1  present only with UART_RX_PARITY_EN; one-cycle pulse.

Behaviour:
- Reset (async assert, sync-released use): 2-flop synchroniser = 1,1; state = IDLE; bit counter, cycle counter and shift register = 0; rx_data = 0; rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err = 0.
- Reset asserted mid-frame: the partial byte is discarded, a held byte is discarded, and no flag pulses.
- Sampling acts only on rxd_s, the synchronised line (2-cycle input latency).
- IDLE: rxd_s == 0 -> START, cycle counter cleared.
- START: when counter reaches HALF_BIT-1, sample. rxd_s == 0 -> DATA with counter cleared. rxd_s == 1 -> IDLE (glitch rejected, no flag).
- DATA: sample every CLKS_PER_BIT cycles (counter == CLKS_PER_BIT-1, then clear). Shift right, so the MSB enters last. After 8 samples -> PARITY if the macro is enabled, otherwise STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rxd_s == 1: byte complete -> IDLE.
  - rxd_s == 0: rx_frame_err pulses, the byte is discarded -> BRK.
- BRK: wait for rxd_s == 1, then -> IDLE. A break therefore never produces spurious bytes.
- Byte complete, holding register empty, or rx_ready high that same cycle: rx_data loads on the next edge and rx_valid = 1. Latency is one cycle from the stop-sample edge.
- Byte complete while rx_valid && !rx_ready: the new byte is dropped, rx_data is unchanged, rx_valid stays 1, and rx_overrun pulses for one cycle.
- rx_valid && rx_ready with no completion that cycle: rx_valid -> 0 next cycle. rx_data keeps its last value.
- A new start edge is accepted in the cycle after STOP -> IDLE. Back-to-back frames are supported.
- Counters saturate at no value: each counter wraps only by explicit clear at its terminal count.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Enabled: frame is 8E1. PARITY state samples one extra bit CLKS_PER_BIT after the last data bit. Mismatch against even parity of the 8 data bits causes:
  - rx_parity_err pulses one cycle at the stop sample;
  - the byte is discarded;
  - the state machine still goes to STOP.
  - A frame with both parity and framing errors pulses both flags in the same cycle.
- Disabled: no PARITY state, no rx_parity_err port, frame is 8N1.

Test Plan:
- Benches use CLKS_PER_BIT = 16.
- Reset, then 8N1 frame 0xA5 with rx_ready held 1 -> rx_valid high for 1 cycle with rx_data = 0xA5, 1 + 16*9.5 + 2 sync cycles after the start edge (±1); no flags.
- Low glitch of 5 cycles on an idle line -> returns to IDLE, rx_busy drops, rx_valid stays 0.
- Frame 0x3C with stop bit low, line held low 40 cycles then high -> one rx_frame_err pulse, no rx_valid. A following 0x81 frame is received correctly.
- Frames 0x11 then 0x22 back-to-back with rx_ready = 0 -> rx_data = 0x11 retained, rx_overrun pulses once at the 0x22 stop sample. rx_ready = 1 then clears rx_valid.
- reset_n pulled low at data bit 4 of frame 0x55, released, then frame 0x66 sent -> only 0x66 delivered; all outputs were 0 during reset.
- UART_RX_PARITY_EN: 0x07 with parity bit 1 -> delivered. Same byte with parity bit 0 -> rx_parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver for the uart0 serial link.
//
// Synchronises the asynchronous uart0_rxd line into system_clk, finds the
// start bit, samples every bit at mid-bit and deframes 8N1 characters (8E1
// when UART_RX_PARITY_EN is defined). Completed bytes are offered to the core
// through a one-entry valid/ready holding register. Framing, overrun and
// (optionally) parity errors are reported as single-cycle pulses.
//
// Build option:
//   UART_RX_PARITY_EN  -- adds an even-parity bit after the data bits and the
//                         rx_parity_err output. Undefined by default (8N1).
//
// Parameters:
//   CLKS_PER_BIT  system_clk cycles per UART bit (legal 4..65535).
//
// Ports:
//   system_clk     in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   uart0_rxd      in   serial line, idles high, asynchronous to system_clk
//   rx_data        out  received byte, LSB = first data bit on the wire
//   rx_valid       out  rx_data holds an unconsumed byte
//   rx_ready       in   consumer takes the byte when rx_valid && rx_ready
//   rx_busy        out  receiver is somewhere other than IDLE
//   rx_frame_err   out  one-cycle pulse: stop bit sampled low
//   rx_overrun     out  one-cycle pulse: byte lost, holding register full
//   rx_parity_err  out  one-cycle pulse: parity mismatch (option only)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       system_clk,
    input  logic       reset_n,
    input  logic       uart0_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    // Terminal counts of the cycle counter: half a bit to reach the middle
    // of the start bit, a full bit between successive samples after that.
    localparam logic [15:0] CNT_HALF_END = 16'(HALF_BIT - 1);
    localparam logic [15:0] CNT_BIT_END  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BRK    = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser. Both flops reset to the idle (high) line level so
    // that releasing reset never looks like a start edge.
    // -------------------------------------------------------------------------
    logic rxd_meta_reg;
    logic rxd_s_reg;

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_reg <= 1'b1;
            rxd_s_reg    <= 1'b1;
        end else begin
            rxd_meta_reg <= uart0_rxd;
            rxd_s_reg    <= rxd_meta_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Deframing state machine
    // -------------------------------------------------------------------------
    state_t      state_reg,      state_next;
    logic [15:0] cnt_reg,        cnt_next;
    logic [2:0]  bit_cnt_reg,    bit_cnt_next;
    logic [7:0]  shift_reg,      shift_next;
    logic        done_reg,       done_next;
    logic        frame_err_reg,  frame_err_next;
    logic        parity_bad;
`ifdef UART_RX_PARITY_EN
    logic        par_bit_reg,    par_bit_next;
    logic        parity_err_reg, parity_err_next;
`endif

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            done_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            done_reg       <= done_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg    <= par_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    // Parity is judged against the fully shifted byte when the stop bit is
    // sampled, so the error pulse lines up with any framing error pulse.
`ifdef UART_RX_PARITY_EN
    assign parity_bad = par_bit_reg ^ (^shift_reg);
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 16'd1;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        done_next       = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next    = par_bit_reg;
        parity_err_next = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rxd_s_reg) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt_reg == CNT_HALF_END) begin
                    cnt_next = '0;
                    if (rxd_s_reg) begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
            end

            DATA: begin
                if (cnt_reg == CNT_BIT_END) begin
                    cnt_next   = '0;
                    // LSB arrives first, so shift right and let the MSB
                    // land in bit 7 on the eighth sample.
                    shift_next = {rxd_s_reg, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == CNT_BIT_END) begin
                    cnt_next     = '0;
                    par_bit_next = rxd_s_reg;
                    state_next   = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt_reg == CNT_BIT_END) begin
                    cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_next = parity_bad;
`endif
                    if (rxd_s_reg) begin
                        done_next  = !parity_bad;
                        state_next = IDLE;
                    end else begin
                        // Stop bit low: either a broken frame or a break.
                        // Park in BRK until the line returns high so a long
                        // low never turns into a stream of 0x00 bytes.
                        frame_err_next = 1'b1;
                        state_next     = BRK;
                    end
                end
            end

            BRK: begin
                cnt_next = '0;
                if (rxd_s_reg) begin
                    state_next = IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // One-entry holding register with valid/ready handshake.
    // done_reg pulses the cycle after the stop sample; shift_reg is stable
    // then because the next frame cannot reach its first data sample yet.
    // -------------------------------------------------------------------------
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       overrun_reg;

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (done_reg) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg  <= shift_reg;
                    rx_valid_reg <= 1'b1;
                end else begin
                    // Consumer still holding the previous byte: keep it,
                    // drop the new one and flag the loss.
                    overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_reg;
    assign rx_valid      = rx_valid_reg;
    assign rx_busy       = (state_reg != IDLE);
    assign rx_frame_err  = frame_err_reg;
    assign rx_overrun    = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx with CLKS_PER_BIT=16.
// Drives serial frames onto uart0_rxd, watches the handshake and error pulses
// with a small event monitor, and checks hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;
    // Start edge to rx_valid: sync (2) + IDLE->START (1) + half bit (8)
    // + 9 (or 10 with parity) full bits + one cycle into the holding register.
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 156 + CPB;
`else
    localparam int LAT = 156;
`endif

    logic       system_clk = 1'b0;
    logic       reset_n    = 1'b0;
    logic       uart0_rxd  = 1'b1;
    logic       rx_ready   = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .system_clk   (system_clk),
        .reset_n      (reset_n),
        .uart0_rxd    (uart0_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    always #5 system_clk = ~system_clk;

    // Event monitor
    int         cyc      = 0;
    int         acc_cnt  = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         perr_cnt = 0;
    logic [7:0] last_data = 8'h00;

    always @(posedge system_clk) begin
        cyc <= cyc + 1;
        if (rx_valid && rx_ready) begin
            acc_cnt   <= acc_cnt + 1;
            last_data <= rx_data;
        end
        if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_overrun)   ovr_cnt  <= ovr_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err) perr_cnt <= perr_cnt + 1;
`endif
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All drives happen 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge system_clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart0_rxd = b;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) uart0_rxd = 1'b1;   // no parity bit in 8N1
`endif
        drive_bit(stop_bit);
        uart0_rxd = 1'b1;
        $display("sent frame 0x%02h stop=%0d par_flip=%0d", d, stop_bit, par_flip);
    endtask

    int         t0, lat, a0, f0, o0, p0;
    logic       got, after_valid;
    logic [7:0] got_data;
    logic [7:0] b;

    initial begin
        // ---------------- reset state ----------------
        idle(3);
        check("reset_valid", rx_valid, 0);
        check("reset_busy",  rx_busy, 0);
        check("reset_data",  rx_data, 0);
        check("reset_ferr",  rx_frame_err, 0);
        check("reset_ovr",   rx_overrun, 0);
        reset_n = 1'b1;
        idle(5);

        // ---------------- frame 0xA5, ready held high ----------------
        rx_ready = 1'b1;
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
        t0 = cyc;
        got = 1'b0; lat = 0; got_data = 8'h00; after_valid = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 400 && !got; i++) begin
                    @(negedge system_clk);
                    if (rx_valid) begin
                        got = 1'b1;
                        lat = cyc - t0;
                        got_data = rx_data;
                    end
                end
                @(negedge system_clk);
                after_valid = rx_valid;
            end
        join
        idle(4);
        check("a5_seen",      got, 1);
        check("a5_data",      got_data, 8'hA5);
        check("a5_latency",   (lat >= LAT - 2 && lat <= LAT), 1);
        check("a5_one_cycle", after_valid, 0);
        check("a5_accepted",  acc_cnt - a0, 1);
        check("a5_no_ferr",   ferr_cnt - f0, 0);
        check("a5_no_ovr",    ovr_cnt - o0, 0);
        check("a5_no_perr",   perr_cnt - p0, 0);
        $display("rx byte 0x%02h latency %0d", got_data, lat);

        // ---------------- 5-cycle low glitch ----------------
        a0 = acc_cnt;
        uart0_rxd = 1'b0;
        idle(5);
        uart0_rxd = 1'b1;
        idle(2);
        check("glitch_busy", rx_busy, 1);
        idle(20);
        check("glitch_idle",  rx_busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_acc",   acc_cnt - a0, 0);
        $display("glitch rejected");

        // ---------------- 0x3C with low stop bit, break, then 0x81 ----------------
        a0 = acc_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        uart0_rxd = 1'b0;
        idle(40);
        check("brk_busy_low", rx_busy, 1);
        uart0_rxd = 1'b1;
        idle(20);
        check("brk_ferr",  ferr_cnt - f0, 1);
        check("brk_acc",   acc_cnt - a0, 0);
        check("brk_idle",  rx_busy, 0);
        a0 = acc_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("post_brk_acc",  acc_cnt - a0, 1);
        check("post_brk_data", last_data, 8'h81);

        // ---------------- overrun: 0x11 then 0x22, ready low ----------------
        rx_ready = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(5);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data",  rx_data, 8'h11);
        check("ovr_pulse", ovr_cnt - o0, 1);
        rx_ready = 1'b1;
        @(posedge system_clk);
        @(negedge system_clk);
        check("ovr_drained",  rx_valid, 0);
        check("ovr_acc",      acc_cnt - a0, 1);
        check("ovr_acc_data", last_data, 8'h11);
        check("ovr_keep_data", rx_data, 8'h11);
        idle(3);

        // ---------------- reset mid-frame 0x55, then 0x66 ----------------
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        b = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        uart0_rxd = b[4];
        idle(8);
        check("mid_busy", rx_busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_busy",  rx_busy, 0);
        check("rst_data",  rx_data, 0);
        check("rst_ferr",  rx_frame_err, 0);
        check("rst_ovr",   rx_overrun, 0);
        idle(3);
        uart0_rxd = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(20);
        send_frame(8'h66, 1'b1, 1'b0);
        idle(20);
        check("rst_acc",       acc_cnt - a0, 1);
        check("rst_data_66",   last_data, 8'h66);
        check("rst_no_flags",  (ferr_cnt - f0) + (ovr_cnt - o0), 0);

`ifdef UART_RX_PARITY_EN
        // ---------------- parity ----------------
        a0 = acc_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);   // parity bit 1
        idle(20);
        check("par_ok_acc",  acc_cnt - a0, 1);
        check("par_ok_data", last_data, 8'h07);
        check("par_ok_perr", perr_cnt - p0, 0);
        a0 = acc_cnt;
        send_frame(8'h07, 1'b1, 1'b1);   // parity bit 0
        idle(20);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_acc",  acc_cnt - a0, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
